multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
// - Multicycle successor to the single-cycle control decoder. Sequences every instruction through
//   FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and drives the datapath strobes for each step.
// - Sits between the instruction register and the shared-memory multicycle datapath. Memory is
//   variable-latency via mem_ready; illegal opcodes are flagged and skipped.
// - Opcode set is unchanged: and, lw, sw, jr, jal, nor, nori, not (nor), bleu, rolv, rorv.
// PARAMETERS
// - INSW       32  instruction width; opcode = ins[INSW-1 -: OPW]
// - OPW        6   opcode field width
// - MEM_HS     1   1: wait on mem_ready in memory states; 0: memory always completes in 1 cycle
// - ALUW       5   ALU operation code width
// PORTS
// - clk          in   1     single clock, rising edge
// - reset        in   1     synchronous, active-high
// - ins          in   INSW  instruction register contents (valid from DECODE on)
// - mem_ready    in   1     memory completed the access this cycle (ignored if MEM_HS=0)
// - pcWrite      out  1     unconditional PC load
// - pcWriteCond  out  1     PC load gated by the datapath bleu comparison
// - pcSrc        out  2     00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 register rs
// - iorD         out  1     memory address: 0 PC, 1 ALUOut
// - memRead      out  1     memory read strobe
// - memWrite     out  1     memory write strobe
// - irWrite      out  1     load instruction register
// - regWriteEnable out 1    register-file write
// - regDst       out  2     00 rt, 01 rd, 10 $31
// - memToReg     out  2     00 ALUOut, 01 MDR, 10 PC
// - aluSrcA      out  1     0 PC, 1 reg A
// - aluSrcB      out  2     00 reg B, 01 const 4, 10 zero-extended imm, 11 sign-extended imm<<2
// - aluOp        out  ALUW  alu_op_t
// - illegal      out  1     1-cycle pulse: undecodable opcode
// - retire       out  1     1-cycle pulse on the last cycle of each instruction
// - state        out  4     current state_t (debug/verification)
// BEHAVIOUR
// - Reset: state<=IDLE on the next edge while reset=1. In IDLE all outputs are 0.
//   IDLE->FETCH on the first cycle with reset=0. Reset in any state aborts the instruction.
//   No strobe is asserted on the cycle after reset is sampled.
// - Outputs are Moore (function of state + latched opcode), except memory-state strobes gated by mem_ready.
// - Unlisted outputs are 0 in every state.
// - FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=ADD.
//   irWrite=pcWrite=mem_ready|~MEM_HS. Stay in FETCH until ready, then go to DECODE.
// - DECODE: aluSrcA=0, aluSrcB=11, aluOp=ADD (precompute branch target). Next state:
//   and/nor/not/rolv/rorv->EXEC_R; nori->EXEC_I; lw/sw->MEMADDR; bleu->BRANCH; jr/jal->JUMP;
//   other->FETCH with illegal=1.
// - EXEC_R: aluSrcA=1, aluSrcB=00, aluOp by opcode (AND/NOR/NOR/ROLV/RORV) -> RWB.
// - EXEC_I: aluSrcA=1, aluSrcB=10, aluOp=NOR -> IWB.
// - RWB: regWriteEnable=1, regDst=01, memToReg=00, retire=1 -> FETCH.
// - IWB: same as RWB with regDst=00.
// - MEMADDR: aluSrcA=1, aluSrcB=10, aluOp=ADD -> MEMRD (lw) or MEMWR (sw).
// - MEMRD: memRead=1, iorD=1; hold until ready -> MEMWB.
// - MEMWB: regWriteEnable=1, regDst=00, memToReg=01, retire=1 -> FETCH.
// - MEMWR: memWrite=1, iorD=1; hold until ready; retire on the ready cycle -> FETCH.
// - BRANCH: aluSrcA=1, aluSrcB=00, aluOp=LEU, pcWriteCond=1, pcSrc=01, retire=1 -> FETCH.
// - JUMP: pcWrite=1, pcSrc=10 (jal) or 11 (jr). jal also sets regWriteEnable=1, regDst=10,
//   memToReg=10. retire=1 -> FETCH.
// - Latency with ready=1 every cycle: R/I/sw 4 cycles, lw 5, bleu/jr/jal 3. Each wait cycle adds 1.
// - mem_ready outside FETCH/MEMRD/MEMWR is ignored. Memory strobes stay asserted throughout a wait.
// - Opcode is latched in DECODE; changes on ins after DECODE do not alter the sequence.
// STRUCTURE
// - Package ctrl_pkg: opcode localparams (AND=100000, LW=100011, SW=101011, JR=001000,
//   JAL=000011, NOR=100110, NORI=001110, NOT=010100, BLEU=010000, ROLV=000000, RORV=000010).
// - ctrl_pkg also holds: alu_op_t {ADD,AND,NOR,ROLV,RORV,LEU}, state_t, and the pcSrc/regDst/memToReg encodings.
// - Sub-module opcode_decode: combinational opcode -> instruction class + ALU op, reused by DECODE/EXEC.
// - Top level holds the state register, latched opcode and output logic.
// TESTING
// - Reset held 3 cycles, then released -> all outputs 0 in IDLE; state=FETCH 1 cycle later.
// - lw (ins[31:26]=100011), mem_ready=1 -> FETCH,DECODE,MEMADDR,MEMRD,MEMWB.
//   retire in cycle 5; memToReg=01 in MEMWB.
// - sw with mem_ready low 2 cycles in MEMWR -> memWrite=1 for 3 cycles; retire only on the 3rd.
// - nori then rorv back-to-back -> IWB regDst=00 aluOp=NOR; RWB regDst=01; EXEC_R aluOp=RORV.
//   Both take 4 cycles.
// - jal -> JUMP pcSrc=10 regDst=10 memToReg=10 regWriteEnable=1; then opcode 111111 -> illegal
//   pulse in DECODE, returns to FETCH, no write.
// - Reset asserted during a MEMRD wait -> IDLE next cycle, no regWriteEnable/retire.
//   A clean fetch follows the release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU operations,
// FSM states, instruction classes and datapath mux selects.
package ctrl_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_NOT  = 6'b010100;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_AND  = 5'd1,
    ALU_NOR  = 5'd2,
    ALU_ROLV = 5'd3,
    ALU_RORV = 5'd4,
    ALU_LEU  = 5'd5
  } alu_op_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_I  = 4'd4,
    S_RWB     = 4'd5,
    S_IWB     = 4'd6,
    S_MEMADDR = 4'd7,
    S_MEMRD   = 4'd8,
    S_MEMWB   = 4'd9,
    S_MEMWR   = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_JR  = 3'd5,
    CLS_JAL = 3'd6,
    CLS_ILL = 3'd7
  } ins_class_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_ZIMM   = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: maps an opcode to its instruction class
// and the ALU operation its execute step needs.
module opcode_decode
  import ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output ins_class_t          ins_class,
  output alu_op_t             alu_op
);

  always_comb begin
    ins_class = CLS_ILL;
    alu_op    = ALU_ADD;
    case (opcode)
      OP_AND:         begin ins_class = CLS_R;   alu_op = ALU_AND;  end
      OP_NOR, OP_NOT: begin ins_class = CLS_R;   alu_op = ALU_NOR;  end
      OP_ROLV:        begin ins_class = CLS_R;   alu_op = ALU_ROLV; end
      OP_RORV:        begin ins_class = CLS_R;   alu_op = ALU_RORV; end
      OP_NORI:        begin ins_class = CLS_I;   alu_op = ALU_NOR;  end
      OP_LW:          begin ins_class = CLS_LW;  alu_op = ALU_ADD;  end
      OP_SW:          begin ins_class = CLS_SW;  alu_op = ALU_ADD;  end
      OP_BLEU:        begin ins_class = CLS_BR;  alu_op = ALU_LEU;  end
      OP_JR:          begin ins_class = CLS_JR;  alu_op = ALU_ADD;  end
      OP_JAL:         begin ins_class = CLS_JAL; alu_op = ALU_ADD;  end
      default:        begin ins_class = CLS_ILL; alu_op = ALU_ADD;  end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: steps each instruction through fetch/decode/execute/
// memory/writeback and drives the datapath strobes for every step.
//
//   state   | meaning
//   IDLE    | after reset, all strobes low
//   FETCH   | read instruction at PC, PC+4 (waits on memory)
//   DECODE  | classify opcode, precompute branch target
//   EXEC_R  | register-register ALU op
//   EXEC_I  | nori ALU op with zero-extended immediate
//   RWB/IWB | write ALU result to rd / rt
//   MEMADDR | compute lw/sw effective address
//   MEMRD   | data read (waits on memory)
//   MEMWB   | write loaded data to rt
//   MEMWR   | data write (waits on memory)
//   BRANCH  | bleu conditional PC load
//   JUMP    | jr/jal PC load, jal links $31
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int INSW   = 32,
  parameter int OPW    = 6,
  parameter int MEM_HS = 1,
  parameter int ALUW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INSW-1:0] ins,
  input  logic            mem_ready,
  output logic            pcWrite,
  output logic            pcWriteCond,
  output logic [1:0]      pcSrc,
  output logic            iorD,
  output logic            memRead,
  output logic            memWrite,
  output logic            irWrite,
  output logic            regWriteEnable,
  output logic [1:0]      regDst,
  output logic [1:0]      memToReg,
  output logic            aluSrcA,
  output logic [1:0]      aluSrcB,
  output logic [ALUW-1:0] aluOp,
  output logic            illegal,
  output logic            retire,
  output logic [3:0]      state
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d, op_sel;
  ins_class_t     cls;
  alu_op_t        dec_alu, alu_op;
  logic           rdy;
  logic           ins_unused;

  assign rdy        = mem_ready || (MEM_HS == 0);
  assign ins_unused = ^ins[INSW-OPW-1:0];

  // In DECODE the live instruction is classified; afterwards only the latched opcode counts.
  assign op_sel = (state_q == S_DECODE) ? ins[INSW-1 -: OPW] : op_q;

  opcode_decode u_decode (
    .opcode    (op_sel),
    .ins_class (cls),
    .alu_op    (dec_alu)
  );

  always_comb begin : next_state
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        op_d = op_sel;
        case (cls)
          CLS_R:           state_d = S_EXEC_R;
          CLS_I:           state_d = S_EXEC_I;
          CLS_LW, CLS_SW:  state_d = S_MEMADDR;
          CLS_BR:          state_d = S_BRANCH;
          CLS_JR, CLS_JAL: state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:  state_d = S_RWB;
      S_EXEC_I:  state_d = S_IWB;
      S_MEMADDR: state_d = (cls == CLS_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (rdy) state_d = S_MEMWB;
      S_MEMWR:   if (rdy) state_d = S_FETCH;
      S_RWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin : strobes
    pcWrite        = 1'b0;
    pcWriteCond    = 1'b0;
    pcSrc          = PCSRC_ALU;
    iorD           = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    irWrite        = 1'b0;
    regWriteEnable = 1'b0;
    regDst         = REGDST_RT;
    memToReg       = M2R_ALUOUT;
    aluSrcA        = 1'b0;
    aluSrcB        = SRCB_REG;
    alu_op         = ALU_ADD;
    illegal        = 1'b0;
    retire         = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = rdy;
        pcWrite = rdy;
      end
      S_DECODE: begin
        aluSrcB = SRCB_BRANCH;
        illegal = (cls == CLS_ILL);
      end
      S_EXEC_R: begin
        aluSrcA = 1'b1;
        alu_op  = dec_alu;
      end
      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_ZIMM;
        alu_op  = dec_alu;
      end
      S_RWB: begin
        regWriteEnable = 1'b1;
        regDst         = REGDST_RD;
        retire         = 1'b1;
      end
      S_IWB: begin
        regWriteEnable = 1'b1;
        retire         = 1'b1;
      end
      S_MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_ZIMM;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEMWB: begin
        regWriteEnable = 1'b1;
        memToReg       = M2R_MDR;
        retire         = 1'b1;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        retire   = rdy;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        alu_op      = dec_alu;
        pcWriteCond = 1'b1;
        pcSrc       = PCSRC_ALUOUT;
        retire      = 1'b1;
      end
      S_JUMP: begin
        pcWrite = 1'b1;
        retire  = 1'b1;
        if (cls == CLS_JAL) begin
          pcSrc          = PCSRC_JUMP;
          regWriteEnable = 1'b1;
          regDst         = REGDST_RA;
          memToReg       = M2R_PC;
        end else begin
          pcSrc = PCSRC_RS;
        end
      end
      default: ;
    endcase
  end

  assign aluOp = ALUW'(alu_op);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the stimulus walks each instruction through the expected
// step list and queues per-cycle outputs; a monitor compares them every cycle.
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, mem_ready;
  logic [31:0] ins;
  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic        regWriteEnable, aluSrcA, illegal, retire;
  logic [1:0]  pcSrc, regDst, memToReg, aluSrcB;
  logic [4:0]  aluOp;
  logic [3:0]  state;

  always #5 clk = ~clk;

  multicycle_control #(.INSW(32), .OPW(6), .MEM_HS(1), .ALUW(5)) dut (
    .clk(clk), .reset(reset), .ins(ins), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regWriteEnable(regWriteEnable), .regDst(regDst), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .illegal(illegal),
    .retire(retire), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_w, pc_wc;
    logic [1:0] pc_src;
    logic       iord, mrd, mwr, irw, rwe;
    logic [1:0] rdst, m2r;
    logic       asa;
    logic [1:0] asb;
    logic [4:0] aop;
    logic       ill, ret;
  } obs_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JR = 5, K_JAL = 6, K_ILL = 7;

  obs_t  exp_q[$];
  string tag_q[$];
  obs_t  act;
  int    checks = 0;
  int    errors = 0;

  always_comb act = {state, pcWrite, pcWriteCond, pcSrc, iorD, memRead, memWrite, irWrite,
                     regWriteEnable, regDst, memToReg, aluSrcA, aluSrcB, aluOp, illegal, retire};

  // Monitor
  initial begin
    obs_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s @%0t: got %h (state %0d) required %h (state %0d)",
                   t, $time, act, act.st, e, e.st);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  // Reference model: what each step of an instruction must show
  function automatic int klass(logic [5:0] op);
    case (op)
      6'b100000, 6'b100110, 6'b010100, 6'b000000, 6'b000010: return K_R;
      6'b001110: return K_I;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b010000: return K_BR;
      6'b001000: return K_JR;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [4:0] r_alu(logic [5:0] op);
    case (op)
      6'b100000: return ALU_AND;
      6'b000000: return ALU_ROLV;
      6'b000010: return ALU_RORV;
      default:   return ALU_NOR;
    endcase
  endfunction

  function automatic obs_t z(state_t s);
    obs_t x = '0;
    x.st = s;
    return x;
  endfunction

  task automatic drive(input obs_t e, input logic r, input logic rst, input logic [31:0] i,
                       input string tag);
    reset     = rst;
    mem_ready = r;
    ins       = i;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // One instruction. fw/mw: wait cycles in fetch and in the data memory step (<0 = random 0..3).
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    logic [31:0] iw;
    obs_t        x;
    int          k, w;
    iw = {op, 26'($urandom)};
    k  = klass(op);
    w  = (fw < 0) ? $urandom_range(0, 3) : fw;
    for (int c = 0; c <= w; c++) begin
      x = z(S_FETCH); x.mrd = 1; x.asb = 2'b01; x.aop = ALU_ADD;
      x.irw = (c == w); x.pc_w = (c == w);
      drive(x, c == w, 0, iw, "fetch");
    end
    x = z(S_DECODE); x.asb = 2'b11; x.aop = ALU_ADD; x.ill = (k == K_ILL);
    drive(x, rbit(), 0, iw, (k == K_ILL) ? "decode_illegal" : "decode");
    w = (mw < 0) ? $urandom_range(0, 3) : mw;
    case (k)
      K_R, K_I: begin
        x = z(k == K_R ? S_EXEC_R : S_EXEC_I); x.asa = 1;
        x.asb = (k == K_R) ? 2'b00 : 2'b10;
        x.aop = (k == K_R) ? r_alu(op) : 5'(ALU_NOR);
        drive(x, rbit(), 0, $urandom, "exec");
        x = z(k == K_R ? S_RWB : S_IWB); x.rwe = 1; x.ret = 1;
        x.rdst = (k == K_R) ? 2'b01 : 2'b00;
        drive(x, rbit(), 0, $urandom, "writeback");
      end
      K_LW, K_SW: begin
        x = z(S_MEMADDR); x.asa = 1; x.asb = 2'b10; x.aop = ALU_ADD;
        drive(x, rbit(), 0, $urandom, "memaddr");
        for (int c = 0; c <= w; c++) begin
          x = z(k == K_LW ? S_MEMRD : S_MEMWR); x.iord = 1;
          if (k == K_LW) x.mrd = 1;
          else begin x.mwr = 1; x.ret = (c == w); end
          drive(x, c == w, 0, $urandom, (k == K_LW) ? "memrd" : "memwr");
        end
        if (k == K_LW) begin
          x = z(S_MEMWB); x.rwe = 1; x.m2r = 2'b01; x.ret = 1;
          drive(x, rbit(), 0, $urandom, "memwb");
        end
      end
      K_BR: begin
        x = z(S_BRANCH); x.asa = 1; x.aop = ALU_LEU; x.pc_wc = 1; x.pc_src = 2'b01; x.ret = 1;
        drive(x, rbit(), 0, $urandom, "branch");
      end
      K_JR, K_JAL: begin
        x = z(S_JUMP); x.pc_w = 1; x.ret = 1;
        if (k == K_JAL) begin x.pc_src = 2'b10; x.rwe = 1; x.rdst = 2'b10; x.m2r = 2'b10; end
        else x.pc_src = 2'b11;
        drive(x, rbit(), 0, $urandom, "jump");
      end
      default: ;
    endcase
  endtask

  logic [5:0] legal_ops [11] = '{6'b100000, 6'b100011, 6'b101011, 6'b001000, 6'b000011,
                                 6'b100110, 6'b001110, 6'b010100, 6'b010000, 6'b000000,
                                 6'b000010};

  initial begin
    obs_t       x;
    logic [5:0] op;
    reset = 1; mem_ready = 0; ins = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive(z(S_IDLE), rbit(), 1, $urandom, "reset_idle");
    drive(z(S_IDLE), 1, 0, $urandom, "release_idle");

    run_instr(6'b100011, 0, 0);               // lw, 5 cycles
    run_instr(6'b101011, 0, 2);               // sw, memWrite held 3 cycles
    run_instr(6'b001110, 0, 0);               // nori
    run_instr(6'b000010, 0, 0);               // rorv
    run_instr(6'b000011, 0, 0);               // jal
    run_instr(6'b111111, 0, 0);               // illegal

    // Reset in the middle of a load's memory wait
    op = 6'b100011;
    x = z(S_FETCH); x.mrd = 1; x.asb = 2'b01; x.irw = 1; x.pc_w = 1;
    drive(x, 1, 0, {op, 26'h0}, "abort_fetch");
    x = z(S_DECODE); x.asb = 2'b11;
    drive(x, 0, 0, {op, 26'h0}, "abort_decode");
    x = z(S_MEMADDR); x.asa = 1; x.asb = 2'b10;
    drive(x, 0, 0, $urandom, "abort_memaddr");
    x = z(S_MEMRD); x.mrd = 1; x.iord = 1;
    drive(x, 0, 0, $urandom, "abort_memrd_wait");
    drive(x, 1, 1, $urandom, "abort_memrd_reset");
    drive(z(S_IDLE), 1, 0, $urandom, "abort_idle");
    run_instr(6'b100000, 0, 0);               // clean instruction after abort

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 11) == 11) begin
        do op = 6'($urandom); while (klass(op) != K_ILL);
      end else begin
        op = legal_ops[$urandom_range(0, 10)];
      end
      run_instr(op, -1, -1);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
